// File: rtl/cardinal_dmem_responder_if.sv
// cardinal_dmem_responder_if: request/response bus between the core's EX/MEM stage and the data memory.
interface cardinal_dmem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_wr;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_wr, resp_rdata
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_wr, resp_rdata
  );
endinterface

// File: rtl/cardinal_dmem_responder.sv
// cardinal_dmem_responder: single-outstanding 256x64 data memory with byte-enabled stores and fixed latency.
module cardinal_dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input logic i_clk,
  input logic i_rst,
  cardinal_dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                  r_state, w_next;
  logic [3:0]              r_cnt, w_cnt;
  logic                    r_wr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_be;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    w_accept, w_go, w_idle, w_wr;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata, w_merged;
  logic [DATA_WIDTH/8-1:0] w_be;
  assign w_idle         = r_state == IDLE;
  assign bus.req_ready  = w_idle & ~i_rst;
  assign bus.resp_valid = r_state == RESP;
  assign bus.resp_wr    = r_wr;
  assign bus.resp_rdata = r_rdata;
  assign w_accept       = bus.req_valid & bus.req_ready;
  // With LATENCY==1 the access happens on the accept edge, so use the live request fields
  assign w_go    = ~i_rst & ((w_idle & w_accept & (LATENCY == 1)) | (r_state == WAIT & r_cnt == 4'd1));
  assign w_wr    = w_idle ? bus.req_wr    : r_wr;
  assign w_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_be    = w_idle ? bus.req_be    : r_be;
  always_comb begin
    w_merged = r_mem[w_addr];
    for (int k = 0; k < DATA_WIDTH/8; k++)
      if (w_wr && w_be[k]) w_merged[8*k +: 8] = w_wdata[8*k +: 8];
  end
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (w_idle && w_accept) begin
      w_next = (LATENCY == 1) ? RESP : WAIT;
      w_cnt  = 4'(LATENCY - 1);
    end else if (r_state == WAIT) begin
      w_cnt  = r_cnt - 4'd1;
      w_next = (r_cnt == 4'd1) ? RESP : WAIT;
    end else if (r_state == RESP && bus.resp_ready) begin
      w_next = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_idle && w_accept) begin
        r_wr    <= bus.req_wr;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
      if (w_go) r_rdata <= w_merged;
    end
  end
  always_ff @(posedge i_clk)
    if (w_go && w_wr) r_mem[w_addr] <= w_merged;
endmodule

// File: tb/tb_cardinal_dmem_responder.sv
// tb_cardinal_dmem_responder: directed scoreboard bench; side instances measure LATENCY=1 and LATENCY=4 timing.
module tb_cardinal_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cardinal_dmem_responder_if bus ();
  cardinal_dmem_responder #(.LATENCY(LAT)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic wr; logic [7:0] addr; logic [63:0] data;} exp_t;
  exp_t        q[$];
  logic [63:0] model [256];
  int          acc_edge = 0;
  logic        prv_rv = 1'b0, prv_rr = 1'b0, prv_wr = 1'b0, last_wr = 1'b0;
  logic [63:0] prv_rd = '0, last_rd = '0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prv_rv = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        exp_t e;
        e.wr   = bus.req_wr;
        e.addr = bus.req_addr;
        e.data = model[bus.req_addr];
        for (int k = 0; k < 8; k++)
          if (bus.req_wr && bus.req_be[k]) e.data[8*k +: 8] = bus.req_wdata[8*k +: 8];
        q.push_back(e);
        acc_edge = cyc + 1;
      end
      if (bus.resp_valid) begin
        chk("req_ready_in_resp", bus.req_ready, 0);
        if (!prv_rv) chk("latency", cyc - acc_edge + 1, LAT);
        else if (!prv_rr) begin
          chk("hold_rdata", bus.resp_rdata, prv_rd);
          chk("hold_wr", bus.resp_wr, prv_wr);
        end
        if (bus.resp_ready) begin
          chk("resp_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("resp_wr", bus.resp_wr, e.wr);
            chk("resp_rdata", bus.resp_rdata, e.data);
            if (e.wr) model[e.addr] = e.data;
          end
          last_rd = bus.resp_rdata;
          last_wr = bus.resp_wr;
        end
      end
      prv_rv = bus.resp_valid;
      prv_rr = bus.resp_ready;
      prv_rd = bus.resp_rdata;
      prv_wr = bus.resp_wr;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = g ? 4 : 1;
    cardinal_dmem_responder_if b ();
    cardinal_dmem_responder #(.LATENCY(L)) u (.i_clk(clk), .i_rst(rst), .bus(b));
    int   last = 0;
    logic have = 1'b0, prv = 1'b0;
    assign b.req_valid  = ~rst;
    assign b.req_wr     = 1'b1;
    assign b.req_addr   = 8'(g);
    assign b.req_wdata  = 64'hC0DE_0000_0000_0000 | 64'(L);
    assign b.req_be     = 8'hFF;
    assign b.resp_ready = 1'b1;
    always @(negedge clk) begin
      if (rst) begin
        have = 1'b0;
        prv  = 1'b0;
      end else begin
        if (b.resp_valid && !prv) begin
          chk($sformatf("latency_L%0d", L), cyc - last + 1, L);
          chk($sformatf("rdata_L%0d", L), b.resp_rdata, 64'hC0DE_0000_0000_0000 | 64'(L));
        end
        if (b.req_valid && b.req_ready) begin
          if (have) chk($sformatf("interval_L%0d", L), cyc + 1 - last, L + 1);
          last = cyc + 1;
          have = 1'b1;
        end
        prv = b.resp_valid;
      end
    end
  end

  task automatic send(input logic wr, input logic [7:0] addr, input logic [63:0] wdata, input logic [7:0] be);
    int i;
    @(posedge clk); #1;
    bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_be = be; bus.req_valid = 1'b1;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    chk("accept_timeout", i < 64, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.resp_valid) break;
    end
    chk("drain_timeout", i < 64, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rv();
    int i;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
    end
    chk("resp_timeout", i < 64, 1);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_be = 0; bus.resp_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_wr", bus.resp_wr, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("req_ready_after_rst", bus.req_ready, 1);
    send(1, 8'h05, 64'h0123_4567_89AB_CDEF, 8'hFF); drain();
    chk("store_ack_wr", last_wr, 1);
    chk("store_ack_data", last_rd, 64'h0123_4567_89AB_CDEF);
    send(0, 8'h05, 64'h0, 8'h00); drain();
    chk("load_wr", last_wr, 0);
    chk("load_data", last_rd, 64'h0123_4567_89AB_CDEF);
    send(1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); drain();
    send(1, 8'h10, 64'h0, 8'hF0); drain();
    chk("partial_ack", last_rd, 64'h0000_0000_FFFF_FFFF);
    send(0, 8'h10, 64'h0, 8'h00); drain();
    chk("partial_load", last_rd, 64'h0000_0000_FFFF_FFFF);
    send(1, 8'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00); drain();
    chk("be0_ack_wr", last_wr, 1);
    chk("be0_ack_data", last_rd, 64'h0000_0000_FFFF_FFFF);
    send(0, 8'h10, 64'h0, 8'h00); drain();
    chk("be0_load", last_rd, 64'h0000_0000_FFFF_FFFF);
    // Backpressure with an ignored store attempt in the middle of the hold
    bus.resp_ready = 0;
    send(0, 8'h05, 64'h0, 8'h00);
    wait_rv();
    @(posedge clk); #1;
    bus.req_wr = 1; bus.req_addr = 8'h05; bus.req_wdata = 64'h0; bus.req_be = 8'hFF; bus.req_valid = 1;
    @(posedge clk); #1 bus.req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_resp_valid", bus.resp_valid, 1);
    chk("bp_req_ready", bus.req_ready, 0);
    bus.resp_ready = 1;
    drain();
    chk("bp_data", last_rd, 64'h0123_4567_89AB_CDEF);
    repeat (6) @(negedge clk);
    chk("bp_no_second_resp", bus.resp_valid, 0);
    send(0, 8'h05, 64'h0, 8'h00); drain();
    chk("bp_array_unchanged", last_rd, 64'h0123_4567_89AB_CDEF);
    send(1, 8'h00, 64'h1111_2222_3333_4444, 8'hFF); drain();
    send(1, 8'hFF, 64'h9999_AAAA_BBBB_CCCC, 8'hFF); drain();
    send(0, 8'h00, 64'h0, 8'h00); drain();
    chk("addr_00", last_rd, 64'h1111_2222_3333_4444);
    send(0, 8'hFF, 64'h0, 8'h00); drain();
    chk("addr_ff", last_rd, 64'h9999_AAAA_BBBB_CCCC);
    // Reset while a store sits in WAIT must discard it
    send(1, 8'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF); drain();
    send(1, 8'h20, 64'h5555_5555_5555_5555, 8'hFF);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_resp", bus.resp_valid, 0);
    send(0, 8'h20, 64'h0, 8'h00); drain();
    chk("store_discarded", last_rd, 64'hAAAA_AAAA_AAAA_AAAA);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
